// File: rtl/color_region_tracker.sv
// color_region_tracker
// Streaming multi-target colour tracker. Every accepted pixel is compared
// against NUM_TARGETS programmable RGB targets using a sum of absolute
// differences (SAD) and a per-target threshold. Over a frame the block counts
// the matching pixels and builds a bounding box for each target. At frame end
// it publishes the results together with a one-cycle strobe.
//
// Ports
//   clk_50, reset              clock (rising edge); synchronous active-high reset
//   pix_valid, sof, r, g, b    pixel stream; sof marks pixel (0,0)
//   targets                    target k at [k*3*CW +: 3*CW], packed {r,g,b}
//   thresholds                 threshold k at [k*THRESH_W +: THRESH_W]
//   min_count                  minimum match count for det
//   match, match_valid         per-pixel match flags, 2 cycles after the pixel
//   result_valid               one-cycle publish strobe
//   det, count, xmin, xmax,    per-target published results, held until the
//   ymin, ymax                 next publish
module color_region_tracker #(
    parameter int NUM_TARGETS = 2,
    parameter int CW          = 8,
    parameter int THRESH_W    = 10,
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480,
    parameter int XW          = 10,
    parameter int YW          = 9,
    parameter int CNT_W       = 19
) (
    input  logic                            clk_50,
    input  logic                            reset,
    input  logic                            pix_valid,
    input  logic                            sof,
    input  logic [CW-1:0]                   r,
    input  logic [CW-1:0]                   g,
    input  logic [CW-1:0]                   b,
    input  logic [NUM_TARGETS*3*CW-1:0]     targets,
    input  logic [NUM_TARGETS*THRESH_W-1:0] thresholds,
    input  logic [CNT_W-1:0]                min_count,
    output logic [NUM_TARGETS-1:0]          match,
    output logic                            match_valid,
    output logic                            result_valid,
    output logic [NUM_TARGETS-1:0]          det,
    output logic [NUM_TARGETS*CNT_W-1:0]    count,
    output logic [NUM_TARGETS*XW-1:0]       xmin,
    output logic [NUM_TARGETS*XW-1:0]       xmax,
    output logic [NUM_TARGETS*YW-1:0]       ymin,
    output logic [NUM_TARGETS*YW-1:0]       ymax
);

    localparam int SAD_W = CW + 2;
    localparam int CMP_W = (THRESH_W > SAD_W) ? THRESH_W : SAD_W;
    localparam logic [XW-1:0]    X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0]    Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        FLUSH   = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    function automatic logic [CW-1:0] abs_diff(input logic [CW-1:0] a, input logic [CW-1:0] b_in);
        if (a >= b_in) begin
            return a - b_in;
        end else begin
            return b_in - a;
        end
    endfunction

    // Control and coordinate state
    state_t         state_q, state_d;
    logic           flush_q, flush_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic           pub_load_s;

    // Per-frame configuration shadows, indexed [target][channel r=2,g=1,b=0]
    logic [NUM_TARGETS-1:0][2:0][CW-1:0]     tgt_q;
    logic [NUM_TARGETS-1:0][THRESH_W-1:0]    thr_q;
    logic [CNT_W-1:0]                        minc_q;

    // Pipeline stage 1 (pixel + coordinates) and stage 2 (distance verdict)
    logic                                    s1_valid_q, s1_sof_q;
    logic [CW-1:0]                           s1_r_q, s1_g_q, s1_b_q;
    logic [XW-1:0]                           s1_x_q, s2_x_q;
    logic [YW-1:0]                           s1_y_q, s2_y_q;
    logic                                    s2_valid_q, s2_sof_q;
    logic [NUM_TARGETS-1:0]                  match_q;
    logic [NUM_TARGETS-1:0][SAD_W-1:0]       sad_s;
    logic [NUM_TARGETS-1:0]                  cmp_s;

    // Accumulators and published results
    logic [NUM_TARGETS-1:0][CNT_W-1:0]       acc_cnt_q, acc_cnt_d, pub_cnt_q;
    logic [NUM_TARGETS-1:0][XW-1:0]          acc_xmin_q, acc_xmin_d, pub_xmin_q;
    logic [NUM_TARGETS-1:0][XW-1:0]          acc_xmax_q, acc_xmax_d, pub_xmax_q;
    logic [NUM_TARGETS-1:0][YW-1:0]          acc_ymin_q, acc_ymin_d, pub_ymin_q;
    logic [NUM_TARGETS-1:0][YW-1:0]          acc_ymax_q, acc_ymax_d, pub_ymax_q;
    logic [NUM_TARGETS-1:0]                  det_s, det_q;
    logic                                    result_valid_q;

    logic           accept_s;
    logic [XW-1:0]  pix_x_s;
    logic [YW-1:0]  pix_y_s;

    // A sof pixel is accepted in any state; other pixels only inside a frame.
    assign accept_s = pix_valid && (sof || (state_q == ACTIVE));
    assign pix_x_s  = sof ? {XW{1'b0}} : x_q;
    assign pix_y_s  = sof ? {YW{1'b0}} : y_q;

    // Next-state, coordinate advance and publish decision
    always_comb begin
        state_d    = state_q;
        flush_d    = flush_q;
        x_d        = x_q;
        y_d        = y_q;
        pub_load_s = 1'b0;
        if (accept_s) begin
            if (pix_x_s == X_LAST) begin
                x_d = {XW{1'b0}};
                y_d = pix_y_s + YW'(1);
            end else begin
                x_d = pix_x_s + XW'(1);
                y_d = pix_y_s;
            end
            // A sof accepted in FLUSH lands here too, dropping the pending publish.
            flush_d = 1'b0;
            state_d = ((pix_x_s == X_LAST) && (pix_y_s == Y_LAST)) ? FLUSH : ACTIVE;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                ACTIVE:  state_d = ACTIVE;
                FLUSH: begin
                    if (flush_q) begin
                        state_d    = PUBLISH;
                        pub_load_s = 1'b1;
                    end else begin
                        flush_d = 1'b1;
                    end
                end
                PUBLISH: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Stage-2 distance: SAD per target and threshold compare
    always_comb begin
        sad_s = '0;
        cmp_s = '0;
        for (int k = 0; k < NUM_TARGETS; k++) begin
            sad_s[k] = SAD_W'(abs_diff(s1_r_q, tgt_q[k][2]))
                     + SAD_W'(abs_diff(s1_g_q, tgt_q[k][1]))
                     + SAD_W'(abs_diff(s1_b_q, tgt_q[k][0]));
            cmp_s[k] = (CMP_W'(sad_s[k]) <= CMP_W'(thr_q[k]));
        end
    end

    // Stage-3 accumulation; a sof entry restarts the frame from that pixel
    always_comb begin
        acc_cnt_d  = acc_cnt_q;
        acc_xmin_d = acc_xmin_q;
        acc_xmax_d = acc_xmax_q;
        acc_ymin_d = acc_ymin_q;
        acc_ymax_d = acc_ymax_q;
        det_s      = '0;
        for (int k = 0; k < NUM_TARGETS; k++) begin
            if (s2_valid_q && (s2_sof_q || (match_q[k] && (acc_cnt_q[k] == {CNT_W{1'b0}})))) begin
                acc_cnt_d[k]  = match_q[k] ? CNT_ONE : {CNT_W{1'b0}};
                acc_xmin_d[k] = match_q[k] ? s2_x_q : {XW{1'b0}};
                acc_xmax_d[k] = match_q[k] ? s2_x_q : {XW{1'b0}};
                acc_ymin_d[k] = match_q[k] ? s2_y_q : {YW{1'b0}};
                acc_ymax_d[k] = match_q[k] ? s2_y_q : {YW{1'b0}};
            end else if (s2_valid_q && match_q[k]) begin
                acc_cnt_d[k]  = (acc_cnt_q[k] == CNT_MAX) ? CNT_MAX : acc_cnt_q[k] + CNT_ONE;
                acc_xmin_d[k] = (s2_x_q < acc_xmin_q[k]) ? s2_x_q : acc_xmin_q[k];
                acc_xmax_d[k] = (s2_x_q > acc_xmax_q[k]) ? s2_x_q : acc_xmax_q[k];
                acc_ymin_d[k] = (s2_y_q < acc_ymin_q[k]) ? s2_y_q : acc_ymin_q[k];
                acc_ymax_d[k] = (s2_y_q > acc_ymax_q[k]) ? s2_y_q : acc_ymax_q[k];
            end else begin
                acc_cnt_d[k]  = acc_cnt_q[k];
            end
            det_s[k] = (acc_cnt_d[k] >= minc_q) && (acc_cnt_d[k] != {CNT_W{1'b0}});
        end
    end

    // State, shadows, pipeline, accumulators and published results
    always_ff @(posedge clk_50) begin
        if (reset) begin
            state_q        <= IDLE;
            flush_q        <= 1'b0;
            x_q            <= {XW{1'b0}};
            y_q            <= {YW{1'b0}};
            tgt_q          <= '0;
            thr_q          <= '0;
            minc_q         <= {CNT_W{1'b0}};
            s1_valid_q     <= 1'b0;
            s1_sof_q       <= 1'b0;
            s1_r_q         <= {CW{1'b0}};
            s1_g_q         <= {CW{1'b0}};
            s1_b_q         <= {CW{1'b0}};
            s1_x_q         <= {XW{1'b0}};
            s1_y_q         <= {YW{1'b0}};
            s2_valid_q     <= 1'b0;
            s2_sof_q       <= 1'b0;
            s2_x_q         <= {XW{1'b0}};
            s2_y_q         <= {YW{1'b0}};
            match_q        <= {NUM_TARGETS{1'b0}};
            acc_cnt_q      <= '0;
            acc_xmin_q     <= '0;
            acc_xmax_q     <= '0;
            acc_ymin_q     <= '0;
            acc_ymax_q     <= '0;
            pub_cnt_q      <= '0;
            pub_xmin_q     <= '0;
            pub_xmax_q     <= '0;
            pub_ymin_q     <= '0;
            pub_ymax_q     <= '0;
            det_q          <= {NUM_TARGETS{1'b0}};
            result_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (accept_s && sof) begin
                tgt_q  <= targets;
                thr_q  <= thresholds;
                minc_q <= min_count;
            end
            s1_valid_q <= accept_s;
            s1_sof_q   <= accept_s && sof;
            s1_r_q     <= r;
            s1_g_q     <= g;
            s1_b_q     <= b;
            s1_x_q     <= pix_x_s;
            s1_y_q     <= pix_y_s;
            s2_valid_q <= s1_valid_q;
            s2_sof_q   <= s1_sof_q;
            s2_x_q     <= s1_x_q;
            s2_y_q     <= s1_y_q;
            match_q    <= s1_valid_q ? cmp_s : {NUM_TARGETS{1'b0}};
            acc_cnt_q  <= acc_cnt_d;
            acc_xmin_q <= acc_xmin_d;
            acc_xmax_q <= acc_xmax_d;
            acc_ymin_q <= acc_ymin_d;
            acc_ymax_q <= acc_ymax_d;
            // The last pixel is accumulated on this same edge, so publish the _d values.
            if (pub_load_s) begin
                pub_cnt_q  <= acc_cnt_d;
                pub_xmin_q <= acc_xmin_d;
                pub_xmax_q <= acc_xmax_d;
                pub_ymin_q <= acc_ymin_d;
                pub_ymax_q <= acc_ymax_d;
                det_q      <= det_s;
            end
            result_valid_q <= pub_load_s;
        end
    end

    assign match        = match_q;
    assign match_valid  = s2_valid_q;
    assign result_valid = result_valid_q;
    assign det          = det_q;
    assign count        = pub_cnt_q;
    assign xmin         = pub_xmin_q;
    assign xmax         = pub_xmax_q;
    assign ymin         = pub_ymin_q;
    assign ymax         = pub_ymax_q;

endmodule

// File: tb/tb_color_region_tracker.sv
module tb_color_region_tracker;

    localparam int N   = 2;
    localparam int CW  = 8;
    localparam int TW  = 10;
    localparam int XW  = 10;
    localparam int YW  = 9;
    localparam int CNW = 2;

    // Result bundle layout: {count, xmin, xmax, ymin, ymax, det}
    localparam logic [81:0] RES_BASE  = {2'd0, 2'd2, 10'd0, 10'd1, 10'd0, 10'd2, 9'd0, 9'd0, 9'd0, 9'd0, 2'b01};
    localparam logic [81:0] RES_MULTI = {2'd1, 2'd2, 10'd3, 10'd1, 10'd3, 10'd2, 9'd1, 9'd0, 9'd1, 9'd0, 2'b01};
    localparam logic [81:0] RES_ONE   = {2'd0, 2'd1, 10'd0, 10'd1, 10'd0, 10'd1, 9'd0, 9'd0, 9'd0, 9'd0, 2'b01};
    localparam logic [81:0] RES_SAT   = {2'd0, 2'd3, 10'd0, 10'd0, 10'd0, 10'd3, 9'd0, 9'd0, 9'd0, 9'd1, 2'b01};
    localparam logic [81:0] RES_ZERO  = 82'd0;

    logic              clk_50 = 1'b0;
    logic              reset = 1'b1;
    logic              pix_valid = 1'b0;
    logic              sof = 1'b0;
    logic [CW-1:0]     r = 8'd0, g = 8'd0, b = 8'd0;
    logic [N*3*CW-1:0] targets = 48'd0;
    logic [N*TW-1:0]   thresholds = 20'd0;
    logic [CNW-1:0]    min_count = 2'd0;
    logic [N-1:0]      match, det;
    logic              match_valid, result_valid;
    logic [N*CNW-1:0]  count;
    logic [N*XW-1:0]   xmin, xmax;
    logic [N*YW-1:0]   ymin, ymax;
    logic [81:0]       res_w;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cyc = 0;
    int rv_count = 0;
    int rv_cyc   = -1;
    logic [N-1:0]  mq[$];
    logic [23:0]   px[8];

    color_region_tracker #(
        .NUM_TARGETS(N), .CW(CW), .THRESH_W(TW), .WIDTH(4), .HEIGHT(2),
        .XW(XW), .YW(YW), .CNT_W(CNW)
    ) dut (
        .clk_50(clk_50), .reset(reset), .pix_valid(pix_valid), .sof(sof),
        .r(r), .g(g), .b(b), .targets(targets), .thresholds(thresholds),
        .min_count(min_count), .match(match), .match_valid(match_valid),
        .result_valid(result_valid), .det(det), .count(count),
        .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax)
    );

    always #10 clk_50 = ~clk_50;

    assign res_w = {count, xmin, xmax, ymin, ymax, det};

    // One clock; sample outputs 1 time unit after the edge.
    task automatic step();
        @(posedge clk_50);
        #1;
        cyc++;
        if (match_valid) mq.push_back(match);
        if (result_valid) begin
            rv_count++;
            rv_cyc = cyc;
        end
    endtask

    task automatic new_frame();
        mq.delete();
        rv_count = 0;
        rv_cyc   = -1;
    endtask

    // {size, match flags of pixels 0..7 at [2i+:2]}
    function automatic logic [23:0] pack_mq();
        logic [15:0] v = 16'd0;
        for (int i = 0; i < mq.size() && i < 8; i++) v[i*2 +: 2] = mq[i];
        return {8'(mq.size()), v};
    endfunction

    task automatic load_base();
        for (int i = 0; i < 8; i++) px[i] = 24'h000000;
        px[1] = 24'hFF0000;
        px[2] = 24'hFE0000;
        px[3] = 24'h191919;
    endtask

    task automatic cfg_multi();
        targets    = {24'h00FF00, 24'hFF0000};
        thresholds = {10'd0, 10'd2};
        min_count  = 2'd2;
    endtask

    // Send pixels 0..n-1 of px[]; optional random gaps; optional config change before pixel corrupt_at.
    task automatic send_pixels(input int n, input bit gaps, input int corrupt_at);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                pix_valid = 1'b0;
                sof       = 1'b0;
                repeat ($urandom_range(0, 2)) step();
            end
            if (i == corrupt_at) begin
                targets    = 48'd0;
                thresholds = {10'h3FF, 10'h3FF};
                min_count  = 2'd0;
            end
            pix_valid = 1'b1;
            sof       = (i == 0);
            {r, g, b} = px[i];
            step();
            last_cyc = cyc;
        end
        pix_valid = 1'b0;
        sof       = 1'b0;
    endtask

    task automatic drain();
        repeat (8) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_checks++;
        if ({res_w, result_valid, match_valid, match} !== 85'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, want 0", {res_w, result_valid, match_valid, match});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_frame_fill();
        targets    = {24'h123456, 24'hFF0000};
        thresholds = {10'd0, 10'd2};
        min_count  = 2'd1;
        load_base();
        new_frame();
        send_pixels(8, 1'b0, -1);
        drain();
        n_checks++;
        if (pack_mq() !== {8'd8, 16'h0014}) begin
            n_fail++;
            $display("FAIL fill_match_seq: got %h, want %h", pack_mq(), {8'd8, 16'h0014});
        end
        n_checks++;
        if (rv_count !== 1 || rv_cyc !== last_cyc + 2) begin
            n_fail++;
            $display("FAIL fill_rv_timing: got count %0d at cyc %0d, want 1 at cyc %0d", rv_count, rv_cyc, last_cyc + 2);
        end
        n_checks++;
        if (res_w !== RES_BASE) begin
            n_fail++;
            $display("FAIL fill_results: got %h, want %h", res_w, RES_BASE);
        end
    endtask

    task automatic test_threshold();
        logic [9:0]  thr_tab[3] = '{10'd2, 10'd1, 10'd0};
        logic [23:0] pix_tab[3] = '{24'hFD0000, 24'hFD0000, 24'hFF0000};
        logic [15:0] mexp[3]    = '{16'h0004, 16'h0000, 16'h0004};
        logic [81:0] rexp[3]    = '{RES_ONE, RES_ZERO, RES_ONE};
        for (int t = 0; t < 3; t++) begin
            targets    = {24'h123456, 24'hFF0000};
            thresholds = {10'd0, thr_tab[t]};
            min_count  = 2'd1;
            for (int i = 0; i < 8; i++) px[i] = 24'h000000;
            px[1] = pix_tab[t];
            new_frame();
            send_pixels(8, 1'b0, -1);
            drain();
            n_checks++;
            if (pack_mq() !== {8'd8, mexp[t]}) begin
                n_fail++;
                $display("FAIL thresh_match_%0d: got %h, want %h", t, pack_mq(), {8'd8, mexp[t]});
            end
            n_checks++;
            if (res_w !== rexp[t]) begin
                n_fail++;
                $display("FAIL thresh_results_%0d: got %h, want %h", t, res_w, rexp[t]);
            end
        end
    endtask

    task automatic test_multi_target();
        cfg_multi();
        load_base();
        px[7] = 24'h00FF00;
        new_frame();
        send_pixels(8, 1'b0, -1);
        drain();
        n_checks++;
        if (pack_mq() !== {8'd8, 16'h8014}) begin
            n_fail++;
            $display("FAIL multi_match_seq: got %h, want %h", pack_mq(), {8'd8, 16'h8014});
        end
        n_checks++;
        if (res_w !== RES_MULTI) begin
            n_fail++;
            $display("FAIL multi_results: got %h, want %h", res_w, RES_MULTI);
        end
    endtask

    task automatic test_saturation();
        targets    = {24'h00FF00, 24'hFF0000};
        thresholds = {10'd0, 10'd2};
        min_count  = 2'd3;
        for (int i = 0; i < 8; i++) px[i] = 24'hFF0000;
        new_frame();
        send_pixels(8, 1'b0, -1);
        drain();
        n_checks++;
        if (res_w !== RES_SAT) begin
            n_fail++;
            $display("FAIL sat_results: got %h, want %h", res_w, RES_SAT);
        end
    endtask

    task automatic test_abort();
        cfg_multi();
        for (int i = 0; i < 8; i++) px[i] = 24'hFF0000;
        new_frame();
        send_pixels(5, 1'b0, -1);
        load_base();
        px[7] = 24'h00FF00;
        send_pixels(8, 1'b0, -1);
        drain();
        n_checks++;
        if (rv_count !== 1 || rv_cyc !== last_cyc + 2) begin
            n_fail++;
            $display("FAIL abort_rv: got count %0d at cyc %0d, want 1 at cyc %0d", rv_count, rv_cyc, last_cyc + 2);
        end
        n_checks++;
        if (res_w !== RES_MULTI) begin
            n_fail++;
            $display("FAIL abort_results: got %h, want %h", res_w, RES_MULTI);
        end
    endtask

    // A sof right after a last pixel (in FLUSH) cancels that frame's publish.
    task automatic test_back_to_back();
        cfg_multi();
        for (int i = 0; i < 8; i++) px[i] = 24'hFF0000;
        new_frame();
        send_pixels(8, 1'b0, -1);
        load_base();
        px[7] = 24'h00FF00;
        send_pixels(8, 1'b0, -1);
        drain();
        n_checks++;
        if (rv_count !== 1 || rv_cyc !== last_cyc + 2) begin
            n_fail++;
            $display("FAIL b2b_rv: got count %0d at cyc %0d, want 1 at cyc %0d", rv_count, rv_cyc, last_cyc + 2);
        end
        n_checks++;
        if (res_w !== RES_MULTI) begin
            n_fail++;
            $display("FAIL b2b_results: got %h, want %h", res_w, RES_MULTI);
        end
    endtask

    task automatic test_shadow_gaps();
        cfg_multi();
        load_base();
        px[7] = 24'h00FF00;
        new_frame();
        send_pixels(8, 1'b1, 3);
        drain();
        n_checks++;
        if (pack_mq() !== {8'd8, 16'h8014}) begin
            n_fail++;
            $display("FAIL shadow_match_seq: got %h, want %h", pack_mq(), {8'd8, 16'h8014});
        end
        n_checks++;
        if (rv_count !== 1 || rv_cyc !== last_cyc + 2) begin
            n_fail++;
            $display("FAIL shadow_rv: got count %0d at cyc %0d, want 1 at cyc %0d", rv_count, rv_cyc, last_cyc + 2);
        end
        n_checks++;
        if (res_w !== RES_MULTI) begin
            n_fail++;
            $display("FAIL shadow_results: got %h, want %h", res_w, RES_MULTI);
        end
    endtask

    task automatic test_reset_nomatch();
        cfg_multi();
        load_base();
        new_frame();
        send_pixels(5, 1'b0, -1);
        reset = 1'b1;
        step();
        n_checks++;
        if ({res_w, result_valid, match_valid, match} !== 85'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: got %h, want 0", {res_w, result_valid, match_valid, match});
        end
        reset = 1'b0;
        step();
        load_base();
        px[7] = 24'h00FF00;
        new_frame();
        send_pixels(8, 1'b0, -1);
        drain();
        n_checks++;
        if (res_w !== RES_MULTI) begin
            n_fail++;
            $display("FAIL post_reset_results: got %h, want %h", res_w, RES_MULTI);
        end
        min_count = 2'd0;
        for (int i = 0; i < 8; i++) px[i] = 24'h808080;
        new_frame();
        send_pixels(8, 1'b0, -1);
        drain();
        n_checks++;
        if (rv_count !== 1 || res_w !== RES_ZERO) begin
            n_fail++;
            $display("FAIL nomatch_results: got rv %0d res %h, want rv 1 res %h", rv_count, res_w, RES_ZERO);
        end
    endtask

    initial begin
        test_reset();
        test_frame_fill();
        test_threshold();
        test_multi_target();
        test_saturation();
        test_abort();
        test_back_to_back();
        test_shadow_gaps();
        test_reset_nomatch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
